alu_serial_16: RTL and testbench
================================

ALU_SERIAL_16 -- requirements
Module: alu_serial_16

Interface
REQ-001 Parameter: WIDTH, 16, operand/result width in bits.
REQ-002 The block SHALL provide clk, input, 1, single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL provide rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL provide start, input, 1, request to begin an operation.
REQ-005 The block SHALL provide A, input, WIDTH, first operand.
REQ-006 The block SHALL provide B, input, WIDTH, second operand.
REQ-007 The block SHALL provide ALUOp, input, 3, operation code: 000 AND, 001 OR, 010 ADD, 110 SUB, 011 XOR; bit 2 = BInvert, bits 1:0 = Operation.
REQ-008 The block SHALL provide busy, output, 1, high while an operation is in progress.
REQ-009 The block SHALL provide done, output, 1, one-cycle pulse when Result is valid.
REQ-010 The block SHALL provide Result, output, WIDTH, registered result.
REQ-011 The block SHALL provide CarryOut, Zero and Overflow, output, 1 each, registered flags.

Function
REQ-012 The block SHALL be a bit-serial executor: it SHALL feed one operand bit pair per cycle, LSB first, into a 1-bit ALU slice.
REQ-013 The FSM SHALL have states IDLE, RUN and DONE; IDLE->RUN on start, RUN->DONE after the WIDTH-th bit, DONE->IDLE unconditionally.
REQ-014 start SHALL be honoured only in IDLE; at the accepting edge the block SHALL latch A, B and ALUOp, clear the bit counter and load the carry register with ALUOp[2].
REQ-015 start in RUN or DONE SHALL be ignored, with no effect on latched operands or the operation in progress.
REQ-016 Each RUN edge SHALL shift the slice result bit into the result shift register, write the slice cout into the carry register, and increment the counter.
REQ-017 busy SHALL be high in RUN, from the accepting edge until the edge that stores bit WIDTH-1.
REQ-018 done SHALL be high for exactly the DONE cycle, WIDTH cycles after the accepting edge (16 for the default).
REQ-019 Result and the flags SHALL update only at RUN->DONE and SHALL hold until the next RUN->DONE.
REQ-020 For ADD/SUB, CarryOut SHALL be the final cout; for logic operations it SHALL be 0.
REQ-021 Zero SHALL equal (Result == 0) for all operations.
REQ-022 Overflow SHALL equal carry-into-MSB XOR carry-out-of-MSB for ADD/SUB, and 0 otherwise.
REQ-023 Unlisted ALUOp codes (100, 101, 111) SHALL execute as their Operation field with BInvert applied, with no error indication.

Reset
REQ-024 rst_n low SHALL immediately force IDLE with busy=0, done=0, Result=0, CarryOut=0, Zero=0, Overflow=0, and the counter and shift registers cleared, including mid-operation.
REQ-025 After rst_n deasserts, the first start SHALL be accepted normally; an aborted operation SHALL produce no done.

Configuration
REQ-026 Macro ALU_SERIAL_FLAGS_EN defined: Zero and Overflow SHALL be computed per REQ-021 and REQ-022.
REQ-027 Macro ALU_SERIAL_FLAGS_EN undefined: the Zero and Overflow logic SHALL be omitted and both ports tied to 0; CarryOut, Result and timing SHALL be unchanged.

Structure
REQ-028 A shared package SHALL hold the ALUOp encodings, the FSM state encoding and the default WIDTH.
REQ-029 The existing alu_1bit SHALL be instantiated once as the datapath slice, with ports a, b, cin, BInvert, Operation, Result and cout; no other sub-modules are allowed.

Verification
REQ-030 ADD: A=0x7FFF, B=0x0001 -> done 16 cycles after start, Result=0x8000, Overflow=1, CarryOut=0, Zero=0.
REQ-031 SUB: A=0x0005, B=0x0005 -> Result=0x0000, Zero=1, CarryOut=1, Overflow=0; and A=0x0000, B=0x0001 -> Result=0xFFFF, CarryOut=0.
REQ-032 Logic ops: A=0xF0F0, B=0x0FF0 -> AND 0x00F0, OR 0xFFF0, XOR 0xFF00, with CarryOut=0 for each.
REQ-033 Start during busy: second start at cycle 5 with different operands -> first result unchanged, only one done pulse.
REQ-034 Reset mid-operation: rst_n low at cycle 8 -> all outputs 0 at once, no done; a new ADD 0x0001+0x0001 after release -> 0x0002.
REQ-035 With ALU_SERIAL_FLAGS_EN undefined, repeat REQ-031 -> Zero=0 and Overflow=0, with Result and CarryOut identical.

Source files
------------

// File: rtl/alu_serial_16_pkg.sv
// Shared definitions for the bit-serial ALU: ALUOp encodings, the
// Operation-field encodings seen by the 1-bit slice, FSM state encoding
// and the default operand width.
package alu_serial_16_pkg;

    localparam int DEFAULT_WIDTH = 16;

    // Full 3-bit ALUOp codes: bit 2 = BInvert, bits 1:0 = Operation
    localparam logic [2:0] ALUOP_AND = 3'b000;
    localparam logic [2:0] ALUOP_OR  = 3'b001;
    localparam logic [2:0] ALUOP_ADD = 3'b010;
    localparam logic [2:0] ALUOP_SUB = 3'b110;
    localparam logic [2:0] ALUOP_XOR = 3'b011;

    // Operation field as decoded by the slice
    localparam logic [1:0] OPER_AND = 2'b00;
    localparam logic [1:0] OPER_OR  = 2'b01;
    localparam logic [1:0] OPER_ADD = 2'b10;
    localparam logic [1:0] OPER_XOR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Arithmetic (ADD/SUB, and the unlisted BInvert variants of them) is
    // identified purely by the Operation field.
    function automatic logic is_arith(input logic [2:0] op);
        return (op[1:0] == OPER_ADD);
    endfunction

endpackage

// File: rtl/alu_serial_16_alu_1bit.sv
// Single-bit ALU slice: optional inversion of b, then AND / OR / full-add /
// XOR selected by Operation. cout is always the full-adder carry; the
// caller decides whether it is meaningful.
module alu_1bit
    import alu_serial_16_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic       BInvert,
    input  logic [1:0] Operation,
    output logic       Result,
    output logic       cout
);

    logic b_eff;

    assign b_eff = b ^ BInvert;

    // Select the bit result for the requested operation
    always_comb begin
        Result = 1'b0;
        case (Operation)
            OPER_AND: Result = a & b_eff;
            OPER_OR:  Result = a | b_eff;
            OPER_ADD: Result = a ^ b_eff ^ cin;
            OPER_XOR: Result = a ^ b_eff;
            default:  Result = 1'b0;
        endcase
    end

    assign cout = (a & b_eff) | (a & cin) | (b_eff & cin);

endmodule

// File: rtl/alu_serial_16.sv
// Bit-serial 16-bit ALU. Operands are latched on an accepted start and
// fed LSB first, one bit per cycle, through a single alu_1bit slice.
// The result is assembled in a shift register and published together
// with the flags on the RUN->DONE edge; done pulses for the DONE cycle.
// Optional feature: define ALU_SERIAL_FLAGS_EN to build the Zero and
// Overflow flag logic; otherwise both outputs are tied low.
module alu_serial_16
    import alu_serial_16_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       ALUOp,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result,
    output logic             CarryOut,
    output logic             Zero,
    output logic             Overflow
);

    localparam int               CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_flag_q, cout_flag_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             slice_res;
    logic             slice_cout;
    logic             last_bit;
    logic [WIDTH-1:0] res_next;

    alu_1bit u_slice (
        .a         (a_q[cnt_q]),
        .b         (b_q[cnt_q]),
        .cin       (carry_q),
        .BInvert   (op_q[2]),
        .Operation (op_q[1:0]),
        .Result    (slice_res),
        .cout      (slice_cout)
    );

    // The bit being stored this cycle enters at the MSB so that after
    // WIDTH shifts bit 0 has arrived at position 0.
    assign res_next = {slice_res, res_sh_q[WIDTH-1:1]};
    assign last_bit = (state_q == ST_RUN) && (cnt_q == LAST);

    // Next-state and datapath update for the serial sequencer
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        carry_d     = carry_q;
        res_sh_d    = res_sh_q;
        result_d    = result_q;
        cout_flag_d = cout_flag_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_RUN;
                    a_d      = A;
                    b_d      = B;
                    op_d     = ALUOp;
                    cnt_d    = '0;
                    carry_d  = ALUOp[2];
                    res_sh_d = '0;
                    busy_d   = 1'b1;
                end
            end
            ST_RUN: begin
                res_sh_d = res_next;
                carry_d  = slice_cout;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d     = ST_DONE;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    result_d    = res_next;
                    cout_flag_d = is_arith(op_q) ? slice_cout : 1'b0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Sequencer, operand, shift and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            carry_q     <= 1'b0;
            res_sh_q    <= '0;
            result_q    <= '0;
            cout_flag_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            carry_q     <= carry_d;
            res_sh_q    <= res_sh_d;
            result_q    <= result_d;
            cout_flag_q <= cout_flag_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

`ifdef ALU_SERIAL_FLAGS_EN
    logic zero_q, zero_d;
    logic ovf_q, ovf_d;

    // Zero and Overflow are captured alongside Result on the final bit;
    // overflow compares the carry into the MSB with the carry out of it.
    always_comb begin
        zero_d = zero_q;
        ovf_d  = ovf_q;
        if (last_bit) begin
            zero_d = (res_next == '0);
            ovf_d  = is_arith(op_q) ? (carry_q ^ slice_cout) : 1'b0;
        end
    end

    // Flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            zero_q <= zero_d;
            ovf_q  <= ovf_d;
        end
    end

    assign Zero     = zero_q;
    assign Overflow = ovf_q;
`else
    logic unused_last_bit;
    assign unused_last_bit = last_bit;
    assign Zero            = 1'b0;
    assign Overflow        = 1'b0;
`endif

    assign busy     = busy_q;
    assign done     = done_q;
    assign Result   = result_q;
    assign CarryOut = cout_flag_q;

endmodule

// File: tb/tb_alu_serial_16.sv
// Scoreboard bench for alu_serial_16: each accepted operation pushes its
// expected outputs and done cycle; a negedge monitor pops and compares
// whenever done is seen. Flag expectations follow ALU_SERIAL_FLAGS_EN.
module tb_alu_serial_16;
    import alu_serial_16_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] A;
    logic [15:0] B;
    logic [2:0]  ALUOp;
    logic        busy;
    logic        done;
    logic [15:0] Result;
    logic        CarryOut;
    logic        Zero;
    logic        Overflow;

    typedef struct {
        logic [15:0] res;
        logic        co;
        logic        z;
        logic        ov;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   n_done = 0;
    int   exp_done = 0;

    alu_serial_16 #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .A        (A),
        .B        (B),
        .ALUOp    (ALUOp),
        .busy     (busy),
        .done     (done),
        .Result   (Result),
        .CarryOut (CarryOut),
        .Zero     (Zero),
        .Overflow (Overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic fl(input logic v);
`ifdef ALU_SERIAL_FLAGS_EN
        return v;
`else
        return 1'b0 & v;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest pending expectation
    always @(negedge clk) begin
        if (done) begin
            exp_t e;
            n_done++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                chk("done_latency", 32'(cyc), 32'(e.cyc));
                chk("result", 32'(Result), 32'(e.res));
                chk("carryout", 32'(CarryOut), 32'(e.co));
                chk("zero", 32'(Zero), 32'(e.z));
                chk("overflow", 32'(Overflow), 32'(e.ov));
                chk("busy_at_done", 32'(busy), 32'd0);
                last_exp = e;
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] res, input logic co, input logic z,
                         input logic ov, input bit push);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        A     = a;
        B     = b;
        ALUOp = op;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        if (push) begin
            e.res = res;
            e.co  = co;
            e.z   = fl(z);
            e.ov  = fl(ov);
            e.cyc = cyc + 16;
            sb.push_back(e);
            exp_done++;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: got %0d pending ops expected 0", sb.size());
            sb.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        A     = '0;
        B     = '0;
        ALUOp = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(Result), 32'd0);
        chk("rst_flags", 32'({CarryOut, Zero, Overflow}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Arithmetic with signed overflow, equal-operand subtract, borrow
        issue(ALUOP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1);
        wait_idle();
        chk("result_hold", 32'(Result), 32'(last_exp.res));
        issue(ALUOP_SUB, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1);
        wait_idle();
        issue(ALUOP_SUB, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_idle();
        issue(ALUOP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1);
        wait_idle();

        // Logic operations, plus an unlisted code (AND with inverted B)
        issue(ALUOP_AND, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_idle();
        issue(ALUOP_OR,  16'hF0F0, 16'h0FF0, 16'hFFF0, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_idle();
        issue(3'b100,    16'hF0F0, 16'h0FF0, 16'hF000, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_idle();
        issue(ALUOP_XOR, 16'hF0F0, 16'h0FF0, 16'hFF00, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_idle();

        // A second start while busy must be ignored
        issue(ALUOP_ADD, 16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        issue(ALUOP_ADD, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_idle();
        repeat (20) @(posedge clk);
        chk("hold_after_ignored_start", 32'(Result), 32'h2345);

        // Reset in the middle of an operation: outputs clear at once
        issue(ALUOP_ADD, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_result", 32'(Result), 32'd0);
        chk("midrst_flags", 32'({CarryOut, Zero, Overflow}), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        issue(ALUOP_ADD, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_idle();
        repeat (5) @(posedge clk);

        chk("done_pulse_count", 32'(n_done), 32'(exp_done));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
